// File: rtl/cfg_sequencer.sv
// ---------------------------------------------------------------------------
// cfg_sequencer
//
// Streams configuration records into a ROWS x COLS processing-element array.
// Each accepted record (PE instruction, LSU config or SPM config) is presented
// on the one-hot select lines and the inst bus for HOLD cycles. An END record
// fires a single-cycle run pulse and parks the sequencer in DONE, where further
// run pulses can be requested with run_req.
//
// Optional feature macro: CFG_SEQ_RANGE_CHECK_EN
//   defined   : PE/LSU records with out-of-range row/col are accepted but
//               dropped, and err is set sticky until reset.
//   undefined : out-of-range indices give an all-zero select for that field;
//               err is always 0.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active low
//   rec_valid  in   record offered
//   rec_ready  out  record accepted when rec_valid & rec_ready
//   rec_kind   in   0=PE 1=LSU 2=SPM 3=END
//   rec_row    in   target row index
//   rec_col    in   target PE column (PE records only)
//   rec_data   in   instruction / SPM configuration word
//   run_req    in   request an extra run pulse while in DONE
//   init_row   out  one-hot row select
//   init_pe    out  one-hot PE select
//   init_lsu   out  LSU configuration strobe
//   init_spm   out  SPM configuration strobe
//   inst       out  configuration word to the array
//   run        out  single-cycle array start pulse
//   busy       out  a record is being presented
//   done       out  configuration finished (END seen)
//   err        out  sticky range error (range-check build only)
//   cfg_count  out  number of accepted PE/LSU/SPM records, saturating
// ---------------------------------------------------------------------------
module cfg_sequencer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int INST_W = 48,
    parameter int HOLD   = 3,
    localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS,
    localparam int IDX_W  = (MAX_RC > 1) ? $clog2(MAX_RC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic [1:0]        rec_kind,
    input  logic [IDX_W-1:0]  rec_row,
    input  logic [IDX_W-1:0]  rec_col,
    input  logic [INST_W-1:0] rec_data,
    input  logic              run_req,
    output logic [ROWS-1:0]   init_row,
    output logic [COLS-1:0]   init_pe,
    output logic              init_lsu,
    output logic              init_spm,
    output logic [INST_W-1:0] inst,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       cfg_count
);

    localparam logic [1:0] KIND_PE  = 2'd0;
    localparam logic [1:0] KIND_LSU = 2'd1;
    localparam logic [1:0] KIND_SPM = 2'd2;
    localparam logic [1:0] KIND_END = 2'd3;

    // Hold counter is loaded with HOLD-1 and the record leaves HOLD when it hits 0.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              rec_ready_q, rec_ready_d;
    logic [ROWS-1:0]   init_row_q,  init_row_d;
    logic [COLS-1:0]   init_pe_q,   init_pe_d;
    logic              init_lsu_q,  init_lsu_d;
    logic              init_spm_q,  init_spm_d;
    logic [INST_W-1:0] inst_q,      inst_d;
    logic              run_q,       run_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic [15:0]       cfg_count_q, cfg_count_d;

    logic accept_s;
    logic range_bad_s;

    // One-hot decode; indices at or beyond ROWS simply select nothing.
    function automatic logic [ROWS-1:0] row_onehot(input logic [IDX_W-1:0] idx);
        logic [ROWS-1:0] r;
        r = {ROWS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            r[i] = (idx == IDX_W'(i));
        end
        return r;
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [IDX_W-1:0] idx);
        logic [COLS-1:0] r;
        r = {COLS{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            r[i] = (idx == IDX_W'(i));
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : (c + 16'd1);
    endfunction

`ifdef CFG_SEQ_RANGE_CHECK_EN
    // One extra bit so that ROWS/COLS of exactly 2**IDX_W still compare correctly.
    localparam logic [IDX_W:0] ROWS_LIM = (IDX_W + 1)'(ROWS);
    localparam logic [IDX_W:0] COLS_LIM = (IDX_W + 1)'(COLS);

    // Flags PE/LSU records whose indices fall outside the array.
    always_comb begin
        range_bad_s = 1'b0;
        case (rec_kind)
            KIND_PE:  range_bad_s = ({1'b0, rec_row} >= ROWS_LIM) || ({1'b0, rec_col} >= COLS_LIM);
            KIND_LSU: range_bad_s = ({1'b0, rec_row} >= ROWS_LIM);
            default:  range_bad_s = 1'b0;
        endcase
    end
`else
    // Range checking disabled: every record is presented.
    always_comb begin
        range_bad_s = 1'b0;
    end
`endif

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        accept_s    = rec_valid && rec_ready_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_row_d  = {ROWS{1'b0}};
        init_pe_d   = {COLS{1'b0}};
        init_lsu_d  = 1'b0;
        init_spm_d  = 1'b0;
        inst_d      = {INST_W{1'b0}};
        run_d       = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        cfg_count_d = cfg_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (rec_kind == KIND_END) begin
                        state_d = ST_DONE;
                        run_d   = 1'b1;
                        done_d  = 1'b1;
                        // The first record after DONE starts a fresh count.
                        if (state_q == ST_DONE) begin
                            cfg_count_d = 16'd0;
                        end else begin
                            cfg_count_d = cfg_count_q;
                        end
                    end else if (range_bad_s) begin
                        // Dropped record: consumed, but state and count untouched.
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                        done_d  = 1'b0;
                        inst_d  = rec_data;
                        if (state_q == ST_DONE) begin
                            cfg_count_d = 16'd1;
                        end else begin
                            cfg_count_d = sat_inc(cfg_count_q);
                        end
                        case (rec_kind)
                            KIND_PE: begin
                                init_row_d = row_onehot(rec_row);
                                init_pe_d  = col_onehot(rec_col);
                            end
                            KIND_LSU: begin
                                init_row_d = row_onehot(rec_row);
                                init_lsu_d = 1'b1;
                            end
                            KIND_SPM: begin
                                init_spm_d = 1'b1;
                            end
                            default: begin
                                inst_d = {INST_W{1'b0}};
                            end
                        endcase
                    end
                end else if ((state_q == ST_DONE) && run_req) begin
                    run_d = 1'b1;
                end else begin
                    run_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                    init_row_d = init_row_q;
                    init_pe_d  = init_pe_q;
                    init_lsu_d = init_lsu_q;
                    init_spm_d = init_spm_q;
                    inst_d     = inst_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        rec_ready_d = (state_d != ST_HOLD);
        busy_d      = (state_d == ST_HOLD);
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rec_ready_q <= 1'b1;
            init_row_q  <= {ROWS{1'b0}};
            init_pe_q   <= {COLS{1'b0}};
            init_lsu_q  <= 1'b0;
            init_spm_q  <= 1'b0;
            inst_q      <= {INST_W{1'b0}};
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cfg_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rec_ready_q <= rec_ready_d;
            init_row_q  <= init_row_d;
            init_pe_q   <= init_pe_d;
            init_lsu_q  <= init_lsu_d;
            init_spm_q  <= init_spm_d;
            inst_q      <= inst_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_count_q <= cfg_count_d;
        end
    end

    assign rec_ready = rec_ready_q;
    assign init_row  = init_row_q;
    assign init_pe   = init_pe_q;
    assign init_lsu  = init_lsu_q;
    assign init_spm  = init_spm_q;
    assign inst      = inst_q;
    assign run       = run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cfg_count = cfg_count_q;

endmodule

// File: tb/tb_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cfg_sequencer
//
// Directed bench for cfg_sequencer (ROWS=4, COLS=8, HOLD=3). COLS=8 widens the
// index fields to 3 bits so an out-of-range row such as 5 can be driven.
// Each step pushes the expected per-cycle output snapshot(s) to a queue; every
// clock tick pops one snapshot and compares it with the sampled outputs.
// ---------------------------------------------------------------------------
module tb_cfg_sequencer;

    localparam int ROWS   = 4;
    localparam int COLS   = 8;
    localparam int INST_W = 48;
    localparam int HOLD   = 3;
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic [ROWS-1:0]   row;
        logic [COLS-1:0]   pe;
        logic              lsu;
        logic              spm;
        logic [INST_W-1:0] inst;
        logic              run;
        logic              ready;
        logic              busy;
        logic              done;
        logic              err;
        logic [15:0]       cnt;
    } snap_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rec_valid;
    logic              rec_ready;
    logic [1:0]        rec_kind;
    logic [IDX_W-1:0]  rec_row;
    logic [IDX_W-1:0]  rec_col;
    logic [INST_W-1:0] rec_data;
    logic              run_req;
    logic [ROWS-1:0]   init_row;
    logic [COLS-1:0]   init_pe;
    logic              init_lsu;
    logic              init_spm;
    logic [INST_W-1:0] inst;
    logic              run;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       cfg_count;

    int    total = 0;
    int    bad   = 0;
    logic  exp_err_v = 1'b0;
    snap_t sb[$];

    always #5 clk = ~clk;

    cfg_sequencer #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .INST_W (INST_W),
        .HOLD   (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_kind  (rec_kind),
        .rec_row   (rec_row),
        .rec_col   (rec_col),
        .rec_data  (rec_data),
        .run_req   (run_req),
        .init_row  (init_row),
        .init_pe   (init_pe),
        .init_lsu  (init_lsu),
        .init_spm  (init_spm),
        .inst      (inst),
        .run       (run),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_count (cfg_count)
    );

    function automatic snap_t mk(input logic [ROWS-1:0] row, input logic [COLS-1:0] pe,
                                 input logic lsu, input logic spm, input logic [INST_W-1:0] d,
                                 input logic r, input logic rdy, input logic bsy,
                                 input logic dn, input logic [15:0] cnt);
        snap_t s;
        s.row = row; s.pe = pe; s.lsu = lsu; s.spm = spm; s.inst = d;
        s.run = r; s.ready = rdy; s.busy = bsy; s.done = dn; s.err = exp_err_v; s.cnt = cnt;
        return s;
    endfunction

    function automatic snap_t idle_snap(input logic r, input logic dn, input logic [15:0] cnt);
        return mk({ROWS{1'b0}}, {COLS{1'b0}}, 1'b0, 1'b0, {INST_W{1'b0}}, r, 1'b1, 1'b0, dn, cnt);
    endfunction

    // Advance one clock, sample just after the edge and compare against the queue head.
    task automatic tick(input string tag);
        snap_t obs;
        snap_t expv;
        @(posedge clk);
        #1;
        total++;
        obs = {init_row, init_pe, init_lsu, init_spm, inst, run, rec_ready, busy, done, err, cfg_count};
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            expv = sb.pop_front();
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_err_v = 1'b0;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd0));
        tick("reset");
        rst = 1'b1;
    endtask

    // Offer one record, expect HOLD cycles of presentation then one ready cycle.
    task automatic do_rec(input logic [1:0] kind, input logic [IDX_W-1:0] row,
                          input logic [IDX_W-1:0] col, input logic [INST_W-1:0] d,
                          input logic [ROWS-1:0] erow, input logic [COLS-1:0] epe,
                          input logic elsu, input logic espm, input logic [15:0] ecnt,
                          input string tag);
        rec_valid = 1'b1;
        rec_kind  = kind;
        rec_row   = row;
        rec_col   = col;
        rec_data  = d;
        for (int i = 0; i < HOLD; i++) begin
            sb.push_back(mk(erow, epe, elsu, espm, d, 1'b0, 1'b0, 1'b1, 1'b0, ecnt));
        end
        sb.push_back(idle_snap(1'b0, 1'b0, ecnt));
        tick(tag);
        rec_valid = 1'b0;
        rec_data  = {INST_W{1'b0}};
        for (int i = 0; i < HOLD; i++) begin
            tick(tag);
        end
    endtask

    task automatic do_end(input logic [15:0] ecnt, input string tag);
        rec_valid = 1'b1;
        rec_kind  = 2'd3;
        sb.push_back(idle_snap(1'b1, 1'b1, ecnt));
        tick(tag);
        rec_valid = 1'b0;
        sb.push_back(idle_snap(1'b0, 1'b1, ecnt));
        tick(tag);
    endtask

    task automatic run_pulse(input logic [15:0] ecnt, input string tag);
        run_req = 1'b1;
        sb.push_back(idle_snap(1'b1, 1'b1, ecnt));
        tick(tag);
        run_req = 1'b0;
        sb.push_back(idle_snap(1'b0, 1'b1, ecnt));
        tick(tag);
    endtask

    initial begin
        logic [INST_W-1:0]  d;
        logic [IDX_W-1:0]   r3;
        logic [IDX_W-1:0]   c3;

        rst       = 1'b0;
        rec_valid = 1'b0;
        rec_kind  = 2'd0;
        rec_row   = {IDX_W{1'b0}};
        rec_col   = {IDX_W{1'b0}};
        rec_data  = {INST_W{1'b0}};
        run_req   = 1'b0;

        do_reset();

        // Single PE record, row 0 col 0.
        do_rec(2'd0, 3'd0, 3'd0, 48'h004708078d9f, 4'b0001, 8'b0000_0001, 1'b0, 1'b0, 16'd1, "pe_r0c0");

        // LSU then SPM back to back; SPM row field must be ignored.
        do_reset();
        do_rec(2'd1, 3'd1, 3'd0, 48'h000000000621, 4'b0010, 8'b0000_0000, 1'b1, 1'b0, 16'd1, "lsu_r1");
        do_rec(2'd2, 3'd2, 3'd3, 48'h000000000005, 4'b0000, 8'b0000_0000, 1'b0, 1'b1, 16'd2, "spm");

        // run_req in IDLE is ignored.
        run_req = 1'b1;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd2));
        tick("runreq_idle");
        run_req = 1'b0;

        // Five PE records, END, then two requested run pulses.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r3 = IDX_W'((i + 1) % 4);
            c3 = IDX_W'((i * 3 + 2) % 8);
            d  = INST_W'({$urandom(), $urandom()});
            do_rec(2'd0, r3, c3, d, 4'b0001 << ((i + 1) % 4), 8'b0000_0001 << ((i * 3 + 2) % 8),
                   1'b0, 1'b0, 16'(i + 1), "pe_seq");
        end
        do_end(16'd5, "end_after5");
        run_pulse(16'd5, "run_req1");
        run_pulse(16'd5, "run_req2");

        // Record and run_req together in DONE: record wins; run_req held through HOLD is ignored.
        run_req = 1'b1;
        do_rec(2'd0, 3'd2, 3'd1, 48'habcdef012345, 4'b0100, 8'b0000_0010, 1'b0, 1'b0, 16'd1, "done_rec_wins");
        run_req = 1'b0;

        // END in IDLE with nothing configured still runs; END again from DONE clears count.
        do_reset();
        do_end(16'd0, "end_idle");
        do_rec(2'd1, 3'd3, 3'd0, 48'h111122223333, 4'b1000, 8'b0000_0000, 1'b1, 1'b0, 16'd1, "lsu_after_done");
        do_end(16'd1, "end_again");
        do_end(16'd0, "end_in_done");

        // Reset in the second HOLD cycle aborts the record, no run pulse afterwards.
        do_reset();
        rec_valid = 1'b1;
        rec_kind  = 2'd0;
        rec_row   = 3'd3;
        rec_col   = 3'd6;
        rec_data  = 48'h0badc0ffee00;
        sb.push_back(mk(4'b1000, 8'b0100_0000, 1'b0, 1'b0, 48'h0badc0ffee00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1));
        sb.push_back(mk(4'b1000, 8'b0100_0000, 1'b0, 1'b0, 48'h0badc0ffee00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1));
        tick("hold_pre_rst");
        rec_valid = 1'b0;
        tick("hold_pre_rst");
        rst = 1'b0;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd0));
        tick("rst_mid_hold");
        rst = 1'b1;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd0));
        tick("after_rst");

        // Out-of-range indices.
        do_reset();
`ifdef CFG_SEQ_RANGE_CHECK_EN
        rec_valid = 1'b1;
        rec_kind  = 2'd0;
        rec_row   = 3'd5;
        rec_col   = 3'd1;
        rec_data  = 48'h123456789abc;
        exp_err_v = 1'b1;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd0));
        tick("oor_pe_drop");
        rec_kind  = 2'd1;
        rec_row   = 3'd6;
        sb.push_back(idle_snap(1'b0, 1'b0, 16'd0));
        tick("oor_lsu_drop");
        rec_valid = 1'b0;
        do_rec(2'd0, 3'd1, 3'd7, 48'h00000000beef, 4'b0010, 8'b1000_0000, 1'b0, 1'b0, 16'd1, "err_sticky");
`else
        do_rec(2'd0, 3'd5, 3'd1, 48'h123456789abc, 4'b0000, 8'b0000_0010, 1'b0, 1'b0, 16'd1, "oor_pe_row");
        do_rec(2'd1, 3'd6, 3'd0, 48'h00000000beef, 4'b0000, 8'b0000_0000, 1'b1, 1'b0, 16'd2, "oor_lsu_row");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
